// File: rtl/signed_divider_pkg.sv
// signed_divider_pkg: shared state encoding and default widths for the signed divider
package signed_divider_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
  localparam int N_WIDTH_DEF = 16;
  localparam int D_WIDTH_DEF = 8;
  localparam int CNT_W_DEF = $clog2(N_WIDTH_DEF);
endpackage

// File: rtl/signed_divider_step.sv
// div_step: one combinational restoring shift-subtract step on magnitudes
module div_step #(
  parameter int D_WIDTH = 8
) (
  input  logic [D_WIDTH-1:0] rem_i,
  input  logic               bit_i,
  input  logic [D_WIDTH-1:0] dmag_i,
  output logic [D_WIDTH-1:0] rem_o,
  output logic               q_o
);
  logic [D_WIDTH:0] trial;
  // shift in the next dividend bit and subtract when the trial covers the divisor
  always_comb begin
    trial = {rem_i, bit_i};
    q_o = trial >= {1'b0, dmag_i};
    rem_o = D_WIDTH'(q_o ? trial - {1'b0, dmag_i} : trial);
  end
endmodule

// File: rtl/signed_divider.sv
// signed_divider: sequential signed restoring divider, one quotient bit per clock
module signed_divider
  import signed_divider_pkg::*;
#(
  parameter int N_WIDTH = N_WIDTH_DEF,
  parameter int D_WIDTH = D_WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [N_WIDTH-1:0] dividend,
  input  logic [D_WIDTH-1:0] divisor,
  output logic [N_WIDTH-1:0] quotient,
  output logic [D_WIDTH-1:0] remainder,
  output logic               busy,
  output logic               done,
  output logic               div_by_zero,
  output logic               overflow
);
  localparam int CW = $clog2(N_WIDTH);
  state_t state_q, state_d;
  logic [N_WIDTH-1:0] n_q, n_d, quot_q, quot_d;
  logic [D_WIDTH-1:0] d_q, d_d, r_q, r_d, rem_q, rem_d, r_next;
  logic [CW-1:0] cnt_q, cnt_d;
  logic qn_q, qn_d, rn_q, rn_d, dbz_q, dbz_d, ovf_q, ovf_d, q_bit;
  div_step #(.D_WIDTH(D_WIDTH)) u_step (
    .rem_i (r_q),
    .bit_i (n_q[N_WIDTH-1]),
    .dmag_i(d_q),
    .rem_o (r_next),
    .q_o   (q_bit)
  );
  // state and datapath registers; reset abandons any division in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      n_q <= '0;
      d_q <= '0;
      r_q <= '0;
      cnt_q <= '0;
      qn_q <= 1'b0;
      rn_q <= 1'b0;
      quot_q <= '0;
      rem_q <= '0;
      dbz_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q <= n_d;
      d_q <= d_d;
      r_q <= r_d;
      cnt_q <= cnt_d;
      qn_q <= qn_d;
      rn_q <= rn_d;
      quot_q <= quot_d;
      rem_q <= rem_d;
      dbz_q <= dbz_d;
      ovf_q <= ovf_d;
    end
  end
  // next state: n_q shifts dividend magnitude out and quotient bits in; zero divisor skips RUN
  always_comb begin
    state_d = state_q;
    n_d = n_q;
    d_d = d_q;
    r_d = r_q;
    cnt_d = cnt_q;
    qn_d = qn_q;
    rn_d = rn_q;
    quot_d = quot_q;
    rem_d = rem_q;
    dbz_d = dbz_q;
    ovf_d = ovf_q;
    case (state_q)
      IDLE: if (start) begin
        n_d = divisor == '0 ? '0 : dividend[N_WIDTH-1] ? -dividend : dividend;
        d_d = divisor[D_WIDTH-1] ? -divisor : divisor;
        qn_d = dividend[N_WIDTH-1] ^ divisor[D_WIDTH-1];
        rn_d = dividend[N_WIDTH-1];
        r_d = '0;
        cnt_d = CW'(N_WIDTH - 1);
        dbz_d = 1'b0;
        ovf_d = 1'b0;
        state_d = divisor == '0 ? FIX : RUN;
      end
      RUN: begin
        n_d = {n_q[N_WIDTH-2:0], q_bit};
        r_d = r_next;
        cnt_d = cnt_q - CW'(1);
        state_d = cnt_q == '0 ? FIX : RUN;
      end
      FIX: begin
        quot_d = qn_q ? -n_q : n_q;
        rem_d = rn_q ? -r_q : r_q;
        ovf_d = !qn_q && n_q[N_WIDTH-1];
        dbz_d = d_q == '0;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  assign quotient = quot_q;
  assign remainder = rem_q;
  assign div_by_zero = dbz_q;
  assign overflow = ovf_q;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
endmodule
